agc_io_unit: RTL and testbench

- Memory-mapped I/O channel block for the AGC-style 15-bit core.
- Provides 8 channels addressed by 3-bit selects:
  - four general output latches
  - a synchronized switch input
  - a prescaled interval timer with overflow interrupt
  - a DSKY display port with strobe
  - a control/status register
- Sits beside the core; the core drives the read select, write select, write enable and write data, and consumes the read data.

---
 rtl/agc_io_unit_if.sv | 17 +
 rtl/agc_io_unit.sv | 118 +++++++++++
 tb/tb_agc_io_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/agc_io_unit_if.sv
// Core-side I/O channel bus: one combinational read port and one clocked write port.
interface agc_io_unit_if;
  logic [2:0]  IO_read_sel;
  logic [14:0] IO_read_data;
  logic        IO_write_en;
  logic [2:0]  IO_write_sel;
  logic [14:0] IO_write_data;

  modport master (
    output IO_read_sel, IO_write_en, IO_write_sel, IO_write_data,
    input  IO_read_data
  );
  modport slave (
    input  IO_read_sel, IO_write_en, IO_write_sel, IO_write_data,
    output IO_read_data
  );
endinterface

// File: rtl/agc_io_unit.sv
// AGC-style 8-channel memory-mapped I/O block: output latches, synced switches,
// prescaled timer (only when AGC_IO_TIMER_EN is defined), DSKY port, control/status.
module agc_io_unit #(
  parameter int TIMER_PRESCALE = 4
) (
  input  logic        clock,
  input  logic        reset,
  agc_io_unit_if.slave bus,
  input  logic [14:0] switch_in,
  output logic [14:0] chan_out0,
  output logic [14:0] chan_out1,
  output logic [14:0] chan_out2,
  output logic [14:0] chan_out3,
  output logic [14:0] dsky_data,
  output logic        dsky_strobe,
  output logic        timer_irq
);

  logic [3:0][14:0] chan_q;
  logic [14:0]      sync1_q, sync2_q;
  logic [14:0]      dsky_q;
  logic             strobe_q;
  logic             irq_en_q;
  logic             ovf;
  logic [14:0]      tmr_rd;

  logic wr_lo, wr6, wr7;
  assign wr_lo = bus.IO_write_en && !bus.IO_write_sel[2];
  assign wr6   = bus.IO_write_en && (bus.IO_write_sel == 3'd6);
  assign wr7   = bus.IO_write_en && (bus.IO_write_sel == 3'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chan_q   <= '0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      dsky_q   <= '0;
      strobe_q <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      if (wr_lo) chan_q[bus.IO_write_sel[1:0]] <= bus.IO_write_data;
      sync1_q  <= switch_in;
      sync2_q  <= sync1_q;
      if (wr6) dsky_q <= bus.IO_write_data;
      strobe_q <= wr6;
      if (wr7) irq_en_q <= bus.IO_write_data[1];
    end
  end

`ifdef AGC_IO_TIMER_EN
  localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;

  logic [14:0]   tmr_q, tmr_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          ovf_q, ovf_d;
  logic          ld, tick;

  assign ld   = bus.IO_write_en && (bus.IO_write_sel == 3'd5);
  assign tick = (pre_q == PW'(TIMER_PRESCALE - 1));

  always_comb begin
    tmr_d = tmr_q;
    pre_d = pre_q;
    ovf_d = ovf_q;
    if (ld) begin
      tmr_d = bus.IO_write_data;
      pre_d = '0;
    end else if (tick) begin
      tmr_d = tmr_q + 15'd1;
      pre_d = '0;
    end else begin
      pre_d = pre_q + 1'b1;
    end
    if (wr7 && bus.IO_write_data[0]) ovf_d = 1'b0;
    // A wrap on the same edge as a W1C clear must still be reported.
    if (!ld && tick && (tmr_q == 15'h7FFF)) ovf_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmr_q <= '0;
      pre_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      pre_q <= pre_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf       = ovf_q;
  assign tmr_rd    = tmr_q;
  assign timer_irq = ovf_q & irq_en_q;
`else
  assign ovf       = 1'b0;
  assign tmr_rd    = '0;
  assign timer_irq = 1'b0;
`endif

  always_comb begin
    bus.IO_read_data = '0;
    case (bus.IO_read_sel)
      3'd0, 3'd1, 3'd2, 3'd3: bus.IO_read_data = chan_q[bus.IO_read_sel[1:0]];
      3'd4:    bus.IO_read_data = sync2_q;
      3'd5:    bus.IO_read_data = tmr_rd;
      3'd6:    bus.IO_read_data = dsky_q;
      default: bus.IO_read_data = {13'd0, irq_en_q, ovf};
    endcase
  end

  assign chan_out0   = chan_q[0];
  assign chan_out1   = chan_q[1];
  assign chan_out2   = chan_q[2];
  assign chan_out3   = chan_q[3];
  assign dsky_data   = dsky_q;
  assign dsky_strobe = strobe_q;

endmodule

// File: tb/tb_agc_io_unit.sv
// Bench for agc_io_unit: directed scenarios plus randomized traffic against a channel-level model.
module tb_agc_io_unit;
  localparam int P = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [14:0] switch_in = '0;
  logic [14:0] chan_out0, chan_out1, chan_out2, chan_out3, dsky_data;
  logic        dsky_strobe, timer_irq;

  agc_io_unit_if bus();

  agc_io_unit #(.TIMER_PRESCALE(P)) dut (
    .clock(clock), .reset(reset), .bus(bus), .switch_in(switch_in),
    .chan_out0(chan_out0), .chan_out1(chan_out1), .chan_out2(chan_out2),
    .chan_out3(chan_out3), .dsky_data(dsky_data), .dsky_strobe(dsky_strobe),
    .timer_irq(timer_irq)
  );

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: channel contents, switch history, timer as "load value + elapsed cycles / P".
  logic [14:0] m_chan [4];
  logic [14:0] m_dsky, m_s1, m_s2;
  logic        m_strobe, m_en, m_ovf;
  int          m_base, m_cyc;

  function automatic logic [14:0] m_tmr();
`ifdef AGC_IO_TIMER_EN
    return 15'((m_base + m_cyc / P) % 32768);
`else
    return 15'd0;
`endif
  endfunction

  function automatic logic [14:0] m_read(input int sel);
    case (sel)
      0, 1, 2, 3: return m_chan[sel];
      4:          return m_s2;
      5:          return m_tmr();
      6:          return m_dsky;
      default:    return {13'd0, m_en, m_ovf};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_chan[i] = '0;
    m_dsky = '0; m_s1 = '0; m_s2 = '0;
    m_strobe = 1'b0; m_en = 1'b0; m_ovf = 1'b0;
    m_base = 0; m_cyc = 0;
  endtask

  // Applies the effect of the upcoming rising edge using the inputs now on the pins.
  task automatic model_edge();
    logic we; int ws; logic [14:0] wd; logic wrap;
    if (reset) begin model_reset(); return; end
    we = bus.IO_write_en; ws = int'(bus.IO_write_sel); wd = bus.IO_write_data;
    wrap = 1'b0;
`ifdef AGC_IO_TIMER_EN
    if (we && ws == 5) begin
      m_base = int'(wd); m_cyc = 0;
    end else begin
      if (((m_cyc + 1) % P == 0) && m_tmr() == 15'h7FFF) wrap = 1'b1;
      m_cyc++;
    end
    m_ovf = wrap | (m_ovf & !(we && ws == 7 && wd[0]));
`endif
    if (we && ws < 4) m_chan[ws] = wd;
    if (we && ws == 6) m_dsky = wd;
    if (we && ws == 7) m_en = wd[1];
    m_strobe = we && ws == 6;
    m_s2 = m_s1; m_s1 = switch_in;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, ".out0"}, chan_out0, m_chan[0]);
    chk({tag, ".out1"}, chan_out1, m_chan[1]);
    chk({tag, ".out2"}, chan_out2, m_chan[2]);
    chk({tag, ".out3"}, chan_out3, m_chan[3]);
    chk({tag, ".dsky"}, dsky_data, m_dsky);
    chk({tag, ".strobe"}, {14'd0, dsky_strobe}, {14'd0, m_strobe});
    chk({tag, ".irq"}, {14'd0, timer_irq}, {14'd0, m_ovf & m_en});
  endtask

  task automatic chk_all_reads(input string tag);
    for (int s = 0; s < 8; s++) begin
      bus.IO_read_sel = 3'(s);
      #1;
      chk($sformatf("%s.rd%0d", tag, s), bus.IO_read_data, m_read(s));
    end
  endtask

  task automatic wr(input int sel, input logic [14:0] data);
    bus.IO_write_en = 1'b1; bus.IO_write_sel = 3'(sel); bus.IO_write_data = data;
    cycle();
    bus.IO_write_en = 1'b0;
  endtask

  task automatic rd(input string tag, input int sel, input logic [14:0] exp);
    bus.IO_read_sel = 3'(sel);
    #1;
    chk(tag, bus.IO_read_data, exp);
    chk({tag, ".model"}, bus.IO_read_data, m_read(sel));
  endtask

  initial begin
    bus.IO_read_sel = '0; bus.IO_write_en = 1'b0;
    bus.IO_write_sel = '0; bus.IO_write_data = '0;
    model_reset();
    #3;
    chk_outs("async_rst");
    cycle(); cycle();
    reset = 1'b0;
    chk_all_reads("rst_idle");
    chk_outs("rst_idle");

    // Ch2 write, with same-cycle read showing the pre-edge value.
    bus.IO_read_sel = 3'd2;
    bus.IO_write_en = 1'b1; bus.IO_write_sel = 3'd2; bus.IO_write_data = 15'h1234;
    #1;
    chk("ch2_same_cycle", bus.IO_read_data, 15'h0000);
    cycle();
    bus.IO_write_en = 1'b0;
    rd("ch2_after", 2, 15'h1234);
    chk("chan_out2", chan_out2, 15'h1234);
    chk_outs("ch2");

    // Switch synchronizer latency and write-protect.
    switch_in = 15'h5A5A;
    cycle();
    rd("sw_edge1", 4, 15'h0000);
    cycle();
    rd("sw_edge2", 4, 15'h5A5A);
    wr(4, 15'h1111);
    rd("sw_wr_ignored", 4, 15'h5A5A);

    // DSKY strobe
    wr(6, 15'h0042);
    chk("dsky_data", dsky_data, 15'h0042);
    chk("dsky_strobe_hi", {14'd0, dsky_strobe}, 15'd1);
    rd("ch6_rd", 6, 15'h0042);
    cycle();
    chk("dsky_strobe_lo", {14'd0, dsky_strobe}, 15'd0);
    wr(6, 15'h0001);
    bus.IO_write_en = 1'b1; bus.IO_write_sel = 3'd6; bus.IO_write_data = 15'h0002;
    cycle();
    bus.IO_write_en = 1'b0;
    chk("dsky_b2b_strobe", {14'd0, dsky_strobe}, 15'd1);
    cycle();
    chk("dsky_b2b_end", {14'd0, dsky_strobe}, 15'd0);

`ifdef AGC_IO_TIMER_EN
    wr(7, 15'h0002);
    wr(5, 15'h7FFE);
    repeat (4) cycle();
    rd("tmr_7fff", 5, 15'h7FFF);
    repeat (4) cycle();
    rd("tmr_wrap", 5, 15'h0000);
    rd("ctl_ovf", 7, 15'h0003);
    chk("irq_set", {14'd0, timer_irq}, 15'd1);
    wr(7, 15'h0003);
    chk("irq_clr", {14'd0, timer_irq}, 15'd0);
    rd("ctl_after_clr", 7, 15'h0002);
`else
    wr(7, 15'h0002);
    rd("ctl_en", 7, 15'h0002);
    wr(5, 15'h1111);
    rd("tmr_off_wr", 5, 15'h0000);
    repeat (100) cycle();
    rd("tmr_off_100", 5, 15'h0000);
    chk("irq_off", {14'd0, timer_irq}, 15'd0);
`endif

    // Randomized traffic, with an asynchronous reset dropped in mid-run.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #3 reset = 1'b1;
        #1;
        model_reset();
        chk_outs("mid_rst");
        chk_all_reads("mid_rst");
        cycle();
        reset = 1'b0;
      end
      bus.IO_write_en   = 1'($urandom_range(0, 1));
      bus.IO_write_sel  = 3'($urandom_range(0, 7));
      bus.IO_write_data = 15'($urandom);
      if (bus.IO_write_sel == 3'd5 && $urandom_range(0, 1) == 1)
        bus.IO_write_data = 15'h7FFF - 15'($urandom_range(0, 3));
      switch_in         = 15'($urandom);
      bus.IO_read_sel   = 3'($urandom_range(0, 7));
      #1;
      chk($sformatf("rnd%0d.rd", i), bus.IO_read_data, m_read(int'(bus.IO_read_sel)));
      cycle();
      chk_outs($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
